triangle_setup: RTL and testbench



---
 rtl/triangle_setup.sv | 213 +++++++++++++++++++++
 tb/tb_triangle_setup.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup.sv
// Triangle setup: edges, vertex 0, saturated determinant and a serial fixed-point reciprocal.
// Optional feature macro BACKFACE_CULL_EN: negative determinants are culled instead of divided.
`ifndef QM
`define QM 16
`endif
`ifndef QF
`define QF 8
`endif

module triangle_setup (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9:0]           vertex_0_x,
    input  logic [9:0]           vertex_1_x,
    input  logic [9:0]           vertex_2_x,
    input  logic [8:0]           vertex_0_y,
    input  logic [8:0]           vertex_1_y,
    input  logic [8:0]           vertex_2_y,
    input  logic [2:0]           vertex_0_z,
    input  logic [2:0]           vertex_1_z,
    input  logic [2:0]           vertex_2_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [10:0]          edge_1_x,
    output logic [10:0]          edge_2_x,
    output logic [9:0]           edge_1_y,
    output logic [9:0]           edge_2_y,
    output logic [3:0]           edge_1_z,
    output logic [3:0]           edge_2_z,
    output logic [9:0]           vertex_0_x_o,
    output logic [8:0]           vertex_0_y_o,
    output logic [2:0]           vertex_0_z_o,
    output logic [`QM-1:0]       determinant,
    output logic [`QM-1:-`QF]    inv_det,
    output logic                 degenerate
`ifdef BACKFACE_CULL_EN
    ,
    output logic                 culled
`endif
);
    localparam int N  = `QM + `QF;
    localparam int CW = $clog2(N);
    localparam logic signed [21:0] DMAX = 22'((2**(`QM-1)) - 1);
    localparam logic signed [21:0] DMIN = 22'(-(2**(`QM-1)));

    typedef enum logic [2:0] {S_IDLE, S_DET, S_DIV, S_SIGN, S_DONE} state_t;

    state_t             r_state;
    logic               r_in_ready, r_out_valid;
    logic [9:0]         r_v0x;
    logic [8:0]         r_v0y;
    logic [2:0]         r_v0z;
    logic signed [10:0] r_e1x, r_e2x;
    logic signed [9:0]  r_e1y, r_e2y;
    logic signed [3:0]  r_e1z, r_e2z;
    logic [21:0]        r_div;
    logic               r_neg;
    logic [22:0]        r_rem;
    logic [N-1:0]       r_quo;
    logic [CW-1:0]      r_cnt;

    logic [10:0]        r_o_e1x, r_o_e2x;
    logic [9:0]         r_o_e1y, r_o_e2y;
    logic [3:0]         r_o_e1z, r_o_e2z;
    logic [9:0]         r_o_v0x;
    logic [8:0]         r_o_v0y;
    logic [2:0]         r_o_v0z;
    logic [`QM-1:0]     r_o_det;
    logic [N-1:0]       r_o_inv;
    logic               r_o_degen;

    logic signed [21:0] w_p1, w_p2, w_d;
    logic [21:0]        w_dabs;
    logic [`QM-1:0]     w_dsat;
    logic               w_zero, w_cull, w_to_done;
    logic               w_nbit, w_ge;
    logic [22:0]        w_rem_sh, w_rem_sub;

    // Edges are held in working registers, so the determinant stays valid through DIV/SIGN.
    assign w_p1   = 22'(r_e1x) * 22'(r_e2y);
    assign w_p2   = 22'(r_e1y) * 22'(r_e2x);
    assign w_d    = w_p1 - w_p2;
    assign w_dabs = w_d[21] ? 22'(-w_d) : w_d;
    assign w_zero = (w_d == 22'sd0);

    always_comb begin
        w_dsat = w_d[`QM-1:0];
        if (w_d > DMAX)
            w_dsat = DMAX[`QM-1:0];
        else if (w_d < DMIN)
            w_dsat = DMIN[`QM-1:0];
    end

`ifdef BACKFACE_CULL_EN
    assign w_cull = w_d[21];
`else
    assign w_cull = 1'b0;
`endif

    assign w_to_done = ((r_state == S_DET) && (w_zero || w_cull)) || (r_state == S_SIGN);

    // Numerator is 2^QF: its only set bit is consumed when the MSB-first counter reaches it.
    assign w_nbit    = (r_cnt == CW'(N - 1 - `QF));
    assign w_rem_sh  = 23'({r_rem, w_nbit});
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_sub = w_rem_sh - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_v0x <= '0; r_v0y <= '0; r_v0z <= '0;
            r_e1x <= '0; r_e1y <= '0; r_e1z <= '0;
            r_e2x <= '0; r_e2y <= '0; r_e2z <= '0;
            r_div <= '0; r_neg <= 1'b0;
            r_rem <= '0; r_quo <= '0; r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_v0x <= vertex_0_x; r_v0y <= vertex_0_y; r_v0z <= vertex_0_z;
                    r_e1x <= $signed({1'b0, vertex_1_x}) - $signed({1'b0, vertex_0_x});
                    r_e2x <= $signed({1'b0, vertex_2_x}) - $signed({1'b0, vertex_0_x});
                    r_e1y <= $signed({1'b0, vertex_1_y}) - $signed({1'b0, vertex_0_y});
                    r_e2y <= $signed({1'b0, vertex_2_y}) - $signed({1'b0, vertex_0_y});
                    r_e1z <= $signed({1'b0, vertex_1_z}) - $signed({1'b0, vertex_0_z});
                    r_e2z <= $signed({1'b0, vertex_2_z}) - $signed({1'b0, vertex_0_z});
                    r_in_ready <= 1'b0;
                    r_state    <= S_DET;
                end
                S_DET: begin
                    r_div <= w_dabs;
                    r_neg <= w_d[21];
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= '0;
                    if (w_zero || w_cull) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_sh;
                    r_quo <= {r_quo[N-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1))
                        r_state <= S_SIGN;
                end
                S_SIGN: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Published results only move on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_e1x <= '0; r_o_e1y <= '0; r_o_e1z <= '0;
            r_o_e2x <= '0; r_o_e2y <= '0; r_o_e2z <= '0;
            r_o_v0x <= '0; r_o_v0y <= '0; r_o_v0z <= '0;
            r_o_det <= '0; r_o_inv <= '0; r_o_degen <= 1'b0;
        end else if (w_to_done) begin
            r_o_e1x <= r_e1x; r_o_e1y <= r_e1y; r_o_e1z <= r_e1z;
            r_o_e2x <= r_e2x; r_o_e2y <= r_e2y; r_o_e2z <= r_e2z;
            r_o_v0x <= r_v0x; r_o_v0y <= r_v0y; r_o_v0z <= r_v0z;
            r_o_det   <= w_dsat;
            r_o_degen <= (r_state == S_DET) && w_zero;
            if (r_state == S_SIGN)
                r_o_inv <= r_neg ? (~r_quo + 1'b1) : r_quo;
            else
                r_o_inv <= '0;
        end
    end

`ifdef BACKFACE_CULL_EN
    logic r_o_cull;
    always_ff @(posedge clk) begin
        if (rst)
            r_o_cull <= 1'b0;
        else if (w_to_done)
            r_o_cull <= (r_state == S_DET) && !w_zero;
    end
    assign culled = r_o_cull;
`endif

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign edge_1_x     = r_o_e1x;
    assign edge_2_x     = r_o_e2x;
    assign edge_1_y     = r_o_e1y;
    assign edge_2_y     = r_o_e2y;
    assign edge_1_z     = r_o_e1z;
    assign edge_2_z     = r_o_e2z;
    assign vertex_0_x_o = r_o_v0x;
    assign vertex_0_y_o = r_o_v0y;
    assign vertex_0_z_o = r_o_v0z;
    assign determinant  = r_o_det;
    assign inv_det      = r_o_inv;
    assign degenerate   = r_o_degen;

endmodule

// File: tb/tb_triangle_setup.sv
// Self-checking bench for triangle_setup: spec vector table, random triangles vs an
// integer-arithmetic model, plus DONE-hold and mid-divide reset sequences.
`timescale 1ns/1ps
`ifndef QM
`define QM 16
`endif
`ifndef QF
`define QF 8
`endif

module tb_triangle_setup;
    localparam int QM   = `QM;
    localparam int QF   = `QF;
    localparam int N    = QM + QF;
    localparam int MAXS = (1 << (QM - 1)) - 1;
    localparam int MINS = -(1 << (QM - 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [9:0]  v0x, v1x, v2x;
    logic [8:0]  v0y, v1y, v2y;
    logic [2:0]  v0z, v1z, v2z;
    logic [10:0] e1x, e2x;
    logic [9:0]  e1y, e2y;
    logic [3:0]  e1z, e2z;
    logic [9:0]  o0x;
    logic [8:0]  o0y;
    logic [2:0]  o0z;
    logic [QM-1:0] det;
    logic [N-1:0]  inv;
    logic          degen;
`ifdef BACKFACE_CULL_EN
    logic          culled;
`endif

    triangle_setup dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .vertex_0_x(v0x), .vertex_1_x(v1x), .vertex_2_x(v2x),
        .vertex_0_y(v0y), .vertex_1_y(v1y), .vertex_2_y(v2y),
        .vertex_0_z(v0z), .vertex_1_z(v1z), .vertex_2_z(v2z),
        .out_valid(out_valid), .out_ready(out_ready),
        .edge_1_x(e1x), .edge_2_x(e2x), .edge_1_y(e1y), .edge_2_y(e2y),
        .edge_1_z(e1z), .edge_2_z(e2z),
        .vertex_0_x_o(o0x), .vertex_0_y_o(o0y), .vertex_0_z_o(o0z),
        .determinant(det), .inv_det(inv), .degenerate(degen)
`ifdef BACKFACE_CULL_EN
        , .culled(culled)
`endif
    );

    typedef struct {
        int x0, y0, z0, x1, y1, z1, x2, y2, z2;
    } tri_t;

    typedef struct {
        logic [10:0] e1x, e2x;
        logic [9:0]  e1y, e2y;
        logic [3:0]  e1z, e2z;
        logic [9:0]  v0x;
        logic [8:0]  v0y;
        logic [2:0]  v0z;
        logic [QM-1:0] det;
        logic [N-1:0]  inv;
        logic          degen;
        logic          cull;
        int            lat;
    } exp_t;

    typedef struct {
        tri_t          t;
        logic [QM-1:0] det;
        logic [N-1:0]  inv;
        logic          degen;
        logic          cull;
        int            lat;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer geometry and division.
    function automatic exp_t model(input tri_t t);
        exp_t r;
        int dx1, dy1, dz1, dx2, dy2, dz2, d, ds, q;
        dx1 = t.x1 - t.x0; dy1 = t.y1 - t.y0; dz1 = t.z1 - t.z0;
        dx2 = t.x2 - t.x0; dy2 = t.y2 - t.y0; dz2 = t.z2 - t.z0;
        d  = dx1 * dy2 - dy1 * dx2;
        ds = (d > MAXS) ? MAXS : ((d < MINS) ? MINS : d);
        r.e1x = 11'(dx1); r.e1y = 10'(dy1); r.e1z = 4'(dz1);
        r.e2x = 11'(dx2); r.e2y = 10'(dy2); r.e2z = 4'(dz2);
        r.v0x = 10'(t.x0); r.v0y = 9'(t.y0); r.v0z = 3'(t.z0);
        r.det   = QM'(ds);
        r.degen = (d == 0);
        r.cull  = 1'b0;
        r.inv   = '0;
        r.lat   = N + 3;
        if (d == 0) begin
            r.lat = 2;
`ifdef BACKFACE_CULL_EN
        end else if (d < 0) begin
            r.cull = 1'b1;
            r.lat  = 2;
`endif
        end else begin
            q = (1 << QF) / ((d < 0) ? -d : d);
            r.inv = N'((d < 0) ? -q : q);
        end
        return r;
    endfunction

    function automatic tri_t mk(input int a0, b0, c0, a1, b1, c1, a2, b2, c2);
        tri_t t;
        t.x0 = a0; t.y0 = b0; t.z0 = c0;
        t.x1 = a1; t.y1 = b1; t.z1 = c1;
        t.x2 = a2; t.y2 = b2; t.z2 = c2;
        return t;
    endfunction

    task automatic drive(input tri_t t);
        v0x = 10'(t.x0); v0y = 9'(t.y0); v0z = 3'(t.z0);
        v1x = 10'(t.x1); v1y = 9'(t.y1); v1z = 3'(t.z1);
        v2x = 10'(t.x2); v2y = 9'(t.y2); v2z = 3'(t.z2);
    endtask

    task automatic check_outs(input string tg, input exp_t e);
        chk({tg, "_e1x"}, e1x, e.e1x);
        chk({tg, "_e1y"}, e1y, e.e1y);
        chk({tg, "_e1z"}, e1z, e.e1z);
        chk({tg, "_e2x"}, e2x, e.e2x);
        chk({tg, "_e2y"}, e2y, e.e2y);
        chk({tg, "_e2z"}, e2z, e.e2z);
        chk({tg, "_v0x"}, o0x, e.v0x);
        chk({tg, "_v0y"}, o0y, e.v0y);
        chk({tg, "_v0z"}, o0z, e.v0z);
        chk({tg, "_det"}, det, e.det);
        chk({tg, "_inv"}, inv, e.inv);
        chk({tg, "_degen"}, degen, e.degen);
`ifdef BACKFACE_CULL_EN
        chk({tg, "_cull"}, culled, e.cull);
`endif
    endtask

    // Leaves the bench at the negedge of cycle 1 (accept edge is cycle 0).
    task automatic start(input tri_t t);
        int g;
        @(negedge clk);
        drive(t);
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_out(input string tg);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tg, "_ovalid_drop"}, out_valid, 0);
        chk({tg, "_in_ready_back"}, in_ready, 1);
    endtask

    function automatic tri_t rand_tri(input int k);
        tri_t t;
        int hi_x, hi_y;
        hi_x = (k % 2 == 0) ? 15 : 1023;
        hi_y = (k % 2 == 0) ? 15 : 511;
        t.x0 = $urandom_range(0, hi_x); t.y0 = $urandom_range(0, hi_y); t.z0 = $urandom_range(0, 7);
        t.x1 = $urandom_range(0, hi_x); t.y1 = $urandom_range(0, hi_y); t.z1 = $urandom_range(0, 7);
        t.x2 = $urandom_range(0, hi_x); t.y2 = $urandom_range(0, hi_y); t.z2 = $urandom_range(0, 7);
        if (k % 7 == 3) begin
            t.x2 = t.x0; t.y2 = t.y0;
        end
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        exp_t e, ez;
        tri_t t1, t2;
        int lat, pulses;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ez = '{default: 0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        check_outs("rst", ez);

        t1 = mk(0, 0, 0, 4, 0, 1, 0, 2, 3);
        t2 = mk(0, 0, 0, 0, 2, 3, 4, 0, 1);
        tbl[0] = '{t: t1, det: 16'h0008, inv: 24'h000020, degen: 0, cull: 0, lat: N + 3};
`ifdef BACKFACE_CULL_EN
        tbl[1] = '{t: t2, det: 16'hFFF8, inv: 24'h000000, degen: 0, cull: 1, lat: 2};
`else
        tbl[1] = '{t: t2, det: 16'hFFF8, inv: 24'hFFFFE0, degen: 0, cull: 0, lat: N + 3};
`endif
        tbl[2] = '{t: mk(0, 0, 0, 2, 2, 0, 4, 4, 0), det: 16'h0000, inv: 24'h0, degen: 1, cull: 0, lat: 2};
        tbl[3] = '{t: mk(0, 0, 0, 639, 0, 0, 0, 479, 0), det: 16'h7FFF, inv: 24'h0, degen: 0, cull: 0, lat: N + 3};

        for (int i = 0; i < 4; i++) begin
            start(tbl[i].t);
            wait_out(lat);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("tbl%0d_det", i), det, tbl[i].det);
            chk($sformatf("tbl%0d_inv", i), inv, tbl[i].inv);
            chk($sformatf("tbl%0d_degen", i), degen, tbl[i].degen);
`ifdef BACKFACE_CULL_EN
            chk($sformatf("tbl%0d_cull", i), culled, tbl[i].cull);
`endif
            check_outs($sformatf("tbl%0d", i), model(tbl[i].t));
            chk($sformatf("tbl%0d_in_ready", i), in_ready, 0);
            release_out($sformatf("tbl%0d", i));
        end

        for (int k = 0; k < 30; k++) begin
            tri_t tr;
            tr = rand_tri(k);
            e  = model(tr);
            start(tr);
            wait_out(lat);
            chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'(e.lat));
            check_outs($sformatf("rnd%0d", k), e);
            release_out($sformatf("rnd%0d", k));
        end

        // Hold DONE with out_ready low while upstream keeps poking in_valid.
        e = model(t1);
        start(t1);
        wait_out(lat);
        chk("hold_lat", 64'(lat), 64'(e.lat));
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            drive(rand_tri(k));
            @(negedge clk);
            check_outs($sformatf("hold%0d", k), e);
            chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
            chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
        end
        in_valid = 1'b0;
        release_out("hold");
        drive(t2);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_next_accepted", in_ready, 0);
        e = model(t2);
        wait_out(lat);
        chk("hold_next_lat", 64'(lat), 64'(e.lat));
        check_outs("hold_next", e);
        release_out("hold_next");

        // Reset during the divide aborts the triangle.
        start(t1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        check_outs("midrst", ez);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("midrst_no_pulse", 64'(pulses), 0);

        e = model(t1);
        start(t1);
        wait_out(lat);
        chk("after_rst_lat", 64'(lat), 64'(e.lat));
        check_outs("after_rst", e);
        release_out("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
